s2_issue_scheduler: RTL and testbench
=====================================

Name: s2_issue_scheduler

Overview:
- Sits in front of the Stage 2 Q15/renormalization datapath.
- Takes a serial stream of symbols, each tagged CDF or Boolean, and packs them into Stage 2 issue bundles: either exactly one CDF symbol, or 1–3 consecutive Booleans in parallel.
- Guarantees the Stage 2 flag contract: bool flags are contiguous from slot 1; a CDF bundle has all flags 0.
- Preserves stream order.

Parameters:
- SYMBOL_WIDTH, 4, symbol width per slot
- CDF_PAYLOAD_WIDTH, 66, opaque CDF fields (UU, VV, lut_u/v/uv, COMP_mux_1) carried to Stage 2
- MAX_WAIT, 4, idle cycles a partial Boolean group may wait before forced issue (≥1)
- WAIT_WIDTH, 3, timeout counter width (2^WAIT_WIDTH > MAX_WAIT)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream symbol valid
- in_ready  out  1  scheduler accepts symbol this cycle
- in_bool  in  1  1 = Boolean symbol, 0 = CDF symbol
- in_symbol  in  SYMBOL_WIDTH  symbol value
- in_cdf_payload  in  CDF_PAYLOAD_WIDTH  CDF operands (ignored for Booleans)
- flush  in  1  end-of-tile pulse: issue any partial group
- flush_done  out  1  one-cycle pulse once all accepted symbols are issued
- out_valid  out  1  bundle valid to Stage 2
- out_ready  in  1  Stage 2 pipeline advance
- out_bool_1, out_bool_2, out_bool_3  out  1 each  Stage 2 bool flags
- out_symbol_1, out_symbol_2, out_symbol_3  out  SYMBOL_WIDTH each  slot symbols
- out_cdf_payload  out  CDF_PAYLOAD_WIDTH  CDF operands

Behaviour:
- Reset (async assert, sync release):
  - out_valid, in_ready and flush_done = 0.
  - All out_bool and out_symbol fields = 0; out_cdf_payload = 0.
  - acc_cnt = 0; timeout counter = 0; state = S_EMPTY.
  - in_ready rises the first cycle after reset release.
- Handshakes:
  - Accept on in_valid && in_ready.
  - Issue on out_valid && out_ready.
  - Output is a registered 1-entry slot; its fields are stable while out_valid && !out_ready.
- in_ready = (state != S_CDF_PEND) && (!out_valid || out_ready) && !flush_pending.
- States: S_EMPTY (acc_cnt = 0), S_ACC (1–2 Booleans held), S_CDF_PEND (Boolean group loaded to output, CDF waiting in hold register).
- Accepted Boolean:
  - If acc_cnt < 2: append to slot acc_cnt+1; go to S_ACC; reset the timeout counter.
  - If acc_cnt = 2: load 3-Boolean bundle (flags 111) into the output slot; acc_cnt = 0; go to S_EMPTY.
- Accepted CDF:
  - In S_EMPTY: load CDF bundle (flags 000, payload) into the output slot.
  - In S_ACC: load partial Boolean bundle (flags 100 or 110) into the output slot, capture the CDF into the hold register, go to S_CDF_PEND.
  - S_CDF_PEND → S_EMPTY on the cycle the Boolean bundle issues; the CDF is loaded into the output slot that same edge.
- Timeout:
  - In S_ACC with no accepted symbol, the counter increments each cycle.
  - When it reaches MAX_WAIT and the output slot is free or draining, the partial group is loaded; go to S_EMPTY.
- Latency: a CDF symbol in S_EMPTY appears on the output 1 cycle after acceptance.
- Flush:
  - Sets flush_pending, which blocks input.
  - A partial group is issued as with timeout, without waiting.
  - flush_done pulses the cycle after the last bundle issues, or 1 cycle after flush if already empty. flush_pending then clears.
  - A flush arriving in S_CDF_PEND completes after the CDF issues.
- Simultaneous accept and issue in the same cycle is allowed; there are no bubbles at full throughput.
- Unused slots always drive symbol 0 and flag 0.
- Reset asserted mid-bundle discards all held symbols; no partial output is emitted.

Optional Feature:
- Macro: S2_SCHED_STATS_EN.
- With the macro defined, add outputs stat_cdf_bundles, stat_bool_bundles and stat_partial_bundles (16 bits each, saturating).
  - Each increments on issue of the matching bundle type.
  - A partial bundle counts in both the Boolean and partial counters.
  - All clear on reset and on flush_done.
- Without the macro, the ports and logic are absent; scheduling behaviour is identical.

Decomposition:
- Package s2_sched_pkg:
  - state enum {S_EMPTY, S_ACC, S_CDF_PEND}
  - bundle struct (3 flags, 3 symbols, payload)
  - constants BOOL_SLOTS = 3, FLAGS_CDF = 3'b000
- Sub-module s2_sched_timeout: the MAX_WAIT counter with clear/enable inputs and an expire output.

Test Plan:
- Reset release, then 6 Booleans back-to-back (symbols 1,0,1,1,0,0) with out_ready=1 → two bundles, flags 111, symbols (1,0,1) then (1,0,0); in_ready never drops.
- Boolean 1, Boolean 0, then CDF (payload 0xABC) → bundle flags 110 (1,0), next cycle flags 000 with payload 0xABC; in_ready low for exactly 1 cycle.
- Single Boolean then idle, MAX_WAIT=4 → flags 100 issued 4 cycles after the last accept.
- out_ready held low 5 cycles with a 3-Boolean bundle pending → outputs stable, in_ready=0, no symbol lost; release drains in order.
- 2 Booleans then flush → flags 110 issued, flush_done pulses 1 cycle after issue, in_ready=0 until then; with S2_SCHED_STATS_EN, partial=1, bool=1.
- Assert reset while in S_CDF_PEND → out_valid=0 immediately, and after release the first CDF input issues as flags 000.

Source files
------------

// File: rtl/s2_sched_pkg.sv
// Shared types and constants for the Stage 2 issue scheduler.
package s2_sched_pkg;

    localparam int unsigned SYM_W      = 4;
    localparam int unsigned PAY_W      = 66;
    localparam int unsigned BOOL_SLOTS = 3;

    localparam logic [BOOL_SLOTS-1:0] FLAGS_CDF  = 3'b000;
    localparam logic [BOOL_SLOTS-1:0] FLAGS_FULL = 3'b111;

    typedef enum logic [1:0] {S_EMPTY, S_ACC, S_CDF_PEND} state_t;

    // flags[0]/syms[0] is slot 1
    typedef struct packed {
        logic [BOOL_SLOTS-1:0]            flags;
        logic [BOOL_SLOTS-1:0][SYM_W-1:0] syms;
        logic [PAY_W-1:0]                 payload;
    } bundle_t;

    function automatic bundle_t cdf_bundle(input logic [SYM_W-1:0] sym,
                                           input logic [PAY_W-1:0] payload);
        bundle_t b;
        b         = '0;
        b.flags   = FLAGS_CDF;
        b.syms[0] = sym;
        b.payload = payload;
        return b;
    endfunction

    // Boolean bundle with the first cnt slots filled; remaining slots stay zero.
    function automatic bundle_t bool_bundle(input logic [1:0] cnt,
                                            input logic [BOOL_SLOTS-1:0][SYM_W-1:0] syms);
        bundle_t b;
        b = '0;
        for (int unsigned i = 0; i < BOOL_SLOTS; i++) begin
            if (i < int'(cnt)) begin
                b.flags[i] = 1'b1;
                b.syms[i]  = syms[i];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/s2_sched_timeout.sv
// Idle counter for a partially filled Boolean group; expires on the MAX_WAIT-th idle cycle.
module s2_sched_timeout #(
    parameter int unsigned MAX_WAIT   = 4,
    parameter int unsigned WAIT_WIDTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [WAIT_WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && count_q != WAIT_WIDTH'(MAX_WAIT)) begin
            count_q <= count_q + WAIT_WIDTH'(1);
        end
    end

    // Stays asserted while saturated so a blocked group issues as soon as the slot frees.
    assign expire = enable && (count_q >= WAIT_WIDTH'(MAX_WAIT - 1));

endmodule

// File: rtl/s2_issue_scheduler.sv
// Packs a CDF/Boolean symbol stream into Stage 2 issue bundles (one CDF or 1-3 Booleans).
// Optional saturating bundle statistics are built when S2_SCHED_STATS_EN is defined.
module s2_issue_scheduler
    import s2_sched_pkg::*;
#(
    parameter int unsigned SYMBOL_WIDTH      = SYM_W,
    parameter int unsigned CDF_PAYLOAD_WIDTH = PAY_W,
    parameter int unsigned MAX_WAIT          = 4,
    parameter int unsigned WAIT_WIDTH        = 3
) (
    input  logic                         clk,
    input  logic                         reset,
`ifdef S2_SCHED_STATS_EN
    output logic [15:0]                  stat_cdf_bundles,
    output logic [15:0]                  stat_bool_bundles,
    output logic [15:0]                  stat_partial_bundles,
`endif
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_bool,
    input  logic [SYMBOL_WIDTH-1:0]      in_symbol,
    input  logic [CDF_PAYLOAD_WIDTH-1:0] in_cdf_payload,
    input  logic                         flush,
    output logic                         flush_done,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_bool_1,
    output logic                         out_bool_2,
    output logic                         out_bool_3,
    output logic [SYMBOL_WIDTH-1:0]      out_symbol_1,
    output logic [SYMBOL_WIDTH-1:0]      out_symbol_2,
    output logic [SYMBOL_WIDTH-1:0]      out_symbol_3,
    output logic [CDF_PAYLOAD_WIDTH-1:0] out_cdf_payload
);

    state_t                             state_q, state_d;
    logic [1:0]                         acc_cnt_q, acc_cnt_d;
    logic [1:0][SYMBOL_WIDTH-1:0]       acc_sym_q, acc_sym_d;
    logic [SYMBOL_WIDTH-1:0]            hold_sym_q, hold_sym_d;
    logic [CDF_PAYLOAD_WIDTH-1:0]       hold_payload_q, hold_payload_d;
    bundle_t                            out_q, out_d, load_bundle;
    logic                               out_valid_q, out_valid_d;
    logic                               flush_pending_q, flush_pending_d;
    logic                               flush_done_q, done_cond;
    logic                               ready_en_q;
    logic                               accept, issue, slot_free, load, tmo_expire;

    assign slot_free = !out_valid_q || out_ready;
    assign issue     = out_valid_q && out_ready;
    assign in_ready  = ready_en_q && (state_q != S_CDF_PEND) && slot_free && !flush_pending_q;
    assign accept    = in_valid && in_ready;

    s2_sched_timeout #(
        .MAX_WAIT   (MAX_WAIT),
        .WAIT_WIDTH (WAIT_WIDTH)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state_q != S_ACC) || accept),
        .enable ((state_q == S_ACC) && !accept),
        .expire (tmo_expire)
    );

    always_comb begin
        state_d        = state_q;
        acc_cnt_d      = acc_cnt_q;
        acc_sym_d      = acc_sym_q;
        hold_sym_d     = hold_sym_q;
        hold_payload_d = hold_payload_q;
        load           = 1'b0;
        load_bundle    = '0;
        unique case (state_q)
            S_EMPTY: begin
                if (accept && in_bool) begin
                    acc_sym_d[0] = in_symbol;
                    acc_cnt_d    = 2'd1;
                    state_d      = S_ACC;
                end else if (accept) begin
                    load        = 1'b1;
                    load_bundle = cdf_bundle(in_symbol, in_cdf_payload);
                end
            end
            S_ACC: begin
                if (accept && in_bool) begin
                    if (acc_cnt_q == 2'd2) begin
                        load        = 1'b1;
                        load_bundle = bool_bundle(2'd3, {in_symbol, acc_sym_q});
                        acc_cnt_d   = 2'd0;
                        state_d     = S_EMPTY;
                    end else begin
                        acc_sym_d[1] = in_symbol;
                        acc_cnt_d    = 2'd2;
                    end
                end else if (accept) begin
                    // CDF behind a partial group: ship the group now, park the CDF
                    load           = 1'b1;
                    load_bundle    = bool_bundle(acc_cnt_q, {{SYMBOL_WIDTH{1'b0}}, acc_sym_q});
                    hold_sym_d     = in_symbol;
                    hold_payload_d = in_cdf_payload;
                    acc_cnt_d      = 2'd0;
                    state_d        = S_CDF_PEND;
                end else if ((tmo_expire || flush_pending_q) && slot_free) begin
                    load        = 1'b1;
                    load_bundle = bool_bundle(acc_cnt_q, {{SYMBOL_WIDTH{1'b0}}, acc_sym_q});
                    acc_cnt_d   = 2'd0;
                    state_d     = S_EMPTY;
                end
            end
            S_CDF_PEND: begin
                if (issue) begin
                    load        = 1'b1;
                    load_bundle = cdf_bundle(hold_sym_q, hold_payload_q);
                    state_d     = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    assign out_d       = load ? load_bundle : (issue ? '0 : out_q);
    assign out_valid_d = load || (out_valid_q && !out_ready);

    // Nothing can be loaded in S_EMPTY while a flush blocks input, so draining the slot finishes it.
    assign done_cond       = flush_pending_q && (state_q == S_EMPTY) && slot_free;
    assign flush_pending_d = (flush_pending_q && !done_cond) || flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= S_EMPTY;
            acc_cnt_q       <= '0;
            acc_sym_q       <= '0;
            hold_sym_q      <= '0;
            hold_payload_q  <= '0;
            out_q           <= '0;
            out_valid_q     <= 1'b0;
            flush_pending_q <= 1'b0;
            flush_done_q    <= 1'b0;
            ready_en_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            acc_cnt_q       <= acc_cnt_d;
            acc_sym_q       <= acc_sym_d;
            hold_sym_q      <= hold_sym_d;
            hold_payload_q  <= hold_payload_d;
            out_q           <= out_d;
            out_valid_q     <= out_valid_d;
            flush_pending_q <= flush_pending_d;
            flush_done_q    <= done_cond;
            ready_en_q      <= 1'b1;
        end
    end

    assign out_valid       = out_valid_q;
    assign flush_done      = flush_done_q;
    assign out_bool_1      = out_q.flags[0];
    assign out_bool_2      = out_q.flags[1];
    assign out_bool_3      = out_q.flags[2];
    assign out_symbol_1    = out_q.syms[0];
    assign out_symbol_2    = out_q.syms[1];
    assign out_symbol_3    = out_q.syms[2];
    assign out_cdf_payload = out_q.payload;

`ifdef S2_SCHED_STATS_EN
    logic [15:0] st_cdf_q, st_bool_q, st_part_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_cdf_q  <= '0;
            st_bool_q <= '0;
            st_part_q <= '0;
        end else if (flush_done_q) begin
            st_cdf_q  <= '0;
            st_bool_q <= '0;
            st_part_q <= '0;
        end else if (issue) begin
            if (out_q.flags == FLAGS_CDF) begin
                st_cdf_q <= sat_inc(st_cdf_q);
            end else begin
                st_bool_q <= sat_inc(st_bool_q);
                if (out_q.flags != FLAGS_FULL) begin
                    st_part_q <= sat_inc(st_part_q);
                end
            end
        end
    end

    assign stat_cdf_bundles     = st_cdf_q;
    assign stat_bool_bundles    = st_bool_q;
    assign stat_partial_bundles = st_part_q;
`endif

endmodule

// File: tb/tb_s2_issue_scheduler.sv
// Directed bench for s2_issue_scheduler with a bundle scoreboard; covers S2_SCHED_STATS_EN too.
module tb_s2_issue_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_bool, flush, flush_done, out_valid, out_ready;
    logic [3:0]  in_symbol, out_symbol_1, out_symbol_2, out_symbol_3;
    logic [65:0] in_cdf_payload, out_cdf_payload;
    logic        out_bool_1, out_bool_2, out_bool_3;
`ifdef S2_SCHED_STATS_EN
    logic [15:0] stat_cdf_bundles, stat_bool_bundles, stat_partial_bundles;
`endif

    int errors = 0;
    int checks = 0;
    logic [80:0] sb[$];
    logic [80:0] obs;

    always #5 clk = ~clk;

    s2_issue_scheduler dut (
        .clk                  (clk),
        .reset                (reset),
`ifdef S2_SCHED_STATS_EN
        .stat_cdf_bundles     (stat_cdf_bundles),
        .stat_bool_bundles    (stat_bool_bundles),
        .stat_partial_bundles (stat_partial_bundles),
`endif
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .in_bool              (in_bool),
        .in_symbol            (in_symbol),
        .in_cdf_payload       (in_cdf_payload),
        .flush                (flush),
        .flush_done           (flush_done),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .out_bool_1           (out_bool_1),
        .out_bool_2           (out_bool_2),
        .out_bool_3           (out_bool_3),
        .out_symbol_1         (out_symbol_1),
        .out_symbol_2         (out_symbol_2),
        .out_symbol_3         (out_symbol_3),
        .out_cdf_payload      (out_cdf_payload)
    );

    assign obs = {out_bool_1, out_bool_2, out_bool_3, out_symbol_1, out_symbol_2, out_symbol_3,
                  out_cdf_payload};

    function automatic logic [80:0] pk(input logic b1, input logic b2, input logic b3,
                                       input logic [3:0] s1, input logic [3:0] s2,
                                       input logic [3:0] s3, input logic [65:0] pay);
        return {b1, b2, b3, s1, s2, s3, pay};
    endfunction

    task automatic check(input string tag, input logic [80:0] got, input logic [80:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every issued bundle must match the oldest expected one.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_empty: got unexpected bundle %0h, required none", obs);
            end else begin
                check("bundle", obs, sb.pop_front());
            end
        end
    end

    task automatic send(input logic b, input logic [3:0] s, input logic [65:0] p,
                        output int waited);
        waited         = 0;
        in_valid       = 1'b1;
        in_bool        = b;
        in_symbol      = s;
        in_cdf_payload = p;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_bound", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int w, tw, issue_c, done_c, early;
        reset = 1'b0; in_valid = 1'b0; in_bool = 1'b0; in_symbol = '0;
        in_cdf_payload = '0; flush = 1'b0; out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_fields", obs, '0);
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        check("rel_in_ready_low", in_ready, 1'b0);
        @(negedge clk);
        check("rel_in_ready_high", in_ready, 1'b1);
        @(posedge clk); #1;

        // Six Booleans back-to-back; payload must be ignored
        sb.push_back(pk(1, 1, 1, 4'd1, 4'd0, 4'd1, '0));
        sb.push_back(pk(1, 1, 1, 4'd1, 4'd0, 4'd0, '0));
        tw = 0;
        send(1, 4'd1, 66'h5A5, w); tw += w;
        send(1, 4'd0, 66'h5A5, w); tw += w;
        send(1, 4'd1, 66'h5A5, w); tw += w;
        send(1, 4'd1, 66'h5A5, w); tw += w;
        send(1, 4'd0, 66'h5A5, w); tw += w;
        send(1, 4'd0, 66'h5A5, w); tw += w;
        check("b2b_no_stall", tw, 0);
        drain();

        // Two Booleans then CDF
        sb.push_back(pk(1, 1, 0, 4'd1, 4'd0, 4'd0, '0));
        sb.push_back(pk(0, 0, 0, 4'd5, 4'd0, 4'd0, 66'hABC));
        send(1, 4'd1, '0, w);
        send(1, 4'd0, '0, w);
        send(0, 4'd5, 66'hABC, w);
        @(negedge clk);
        check("cdf_pend_ready_low", in_ready, 1'b0);
        @(negedge clk);
        check("cdf_pend_ready_back", in_ready, 1'b1);
        drain();

        // CDF from empty appears one cycle after acceptance
        sb.push_back(pk(0, 0, 0, 4'd7, 4'd0, 4'd0, 66'h2_0000_0000_0000_0123));
        send(0, 4'd7, 66'h2_0000_0000_0000_0123, w);
        @(negedge clk);
        check("cdf_latency", out_valid, 1'b1);
        drain();

        // Single Boolean then idle: issued on the fourth idle cycle
        sb.push_back(pk(1, 0, 0, 4'd9, 4'd0, 4'd0, '0));
        send(1, 4'd9, '0, w);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("timeout_wait", out_valid, 1'b0);
        end
        @(negedge clk);
        check("timeout_fire", out_valid, 1'b1);
        drain();

        // Back-pressure: full bundle held five cycles while a CDF waits
        out_ready = 1'b0;
        sb.push_back(pk(1, 1, 1, 4'd2, 4'd3, 4'd4, '0));
        sb.push_back(pk(0, 0, 0, 4'd6, 4'd0, 4'd0, 66'h55));
        send(1, 4'd2, '0, w);
        send(1, 4'd3, '0, w);
        send(1, 4'd4, '0, w);
        in_valid = 1'b1; in_bool = 1'b0; in_symbol = 4'd6; in_cdf_payload = 66'h55;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_ready", in_ready, 1'b0);
            check("stall_hold", {out_valid, obs}, {1'b1, pk(1, 1, 1, 4'd2, 4'd3, 4'd4, '0)});
        end
        @(posedge clk); #1; out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_ready", in_ready, 1'b1);
        @(posedge clk); #1; in_valid = 1'b0;
        drain();

        // Flush while empty (also clears any statistics)
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        check("eflush_ready", in_ready, 1'b0);
        check("eflush_done_early", flush_done, 1'b0);
        @(negedge clk);
        check("eflush_done", flush_done, 1'b1);
        @(posedge clk); #1;

        // Two Booleans then flush
        sb.push_back(pk(1, 1, 0, 4'd3, 4'd5, 4'd0, '0));
        send(1, 4'd3, '0, w);
        send(1, 4'd5, '0, w);
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        issue_c = -1; done_c = -1; early = 0;
        for (int c = 0; c < 20 && done_c < 0; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) issue_c = c;
            if (flush_done) begin
                done_c = c;
`ifdef S2_SCHED_STATS_EN
                check("stat_partial", stat_partial_bundles, 16'd1);
                check("stat_bool", stat_bool_bundles, 16'd1);
                check("stat_cdf", stat_cdf_bundles, 16'd0);
`endif
            end else if (in_ready) begin
                early++;
            end
        end
        check("flush_issue_cycle", issue_c, 1);
        check("flush_done_cycle", done_c, 2);
        check("flush_ready_blocked", early, 0);
        drain();

        // Reset while a CDF is parked behind a Boolean group
        out_ready = 1'b0;
        send(1, 4'd8, '0, w);
        send(0, 4'd2, 66'h77, w);
        #2; reset = 1'b0; #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_fields", obs, '0);
        @(posedge clk); #1; reset = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        sb.push_back(pk(0, 0, 0, 4'hE, 4'd0, 4'd0, 66'h3_FFFF_0000_1234_5678));
        send(0, 4'hE, 66'h3_FFFF_0000_1234_5678, w);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
